// File: rtl/memory_stage_if.sv
// rtl/memory_stage_if.sv - data bus between the MEM stage and data memory
//
// Purpose: carries one data-bus request (valid/addr/size/strobe/data) from the
// MEM stage and the matching response (addr_ok/data_ok/data) back to it.
// Ports (modports):
//   master - MEM stage side: drives dreq_*, samples dresp_*
//   slave  - memory side:    samples dreq_*, drives dresp_*

interface memory_stage_if;
  logic        dreq_valid;
  logic [63:0] dreq_addr;
  logic [2:0]  dreq_size;
  logic [7:0]  dreq_strobe;
  logic [63:0] dreq_data;
  logic        dresp_addr_ok;
  logic        dresp_data_ok;
  logic [63:0] dresp_data;

  modport master (
    output dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
    input  dresp_addr_ok, dresp_data_ok, dresp_data
  );

  modport slave (
    input  dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
    output dresp_addr_ok, dresp_data_ok, dresp_data
  );
endinterface

// File: rtl/memory_stage.sv
// rtl/memory_stage.sv - RV64 pipeline MEM stage with data-bus load/store
//
// Purpose: registers the execute result towards writeback, performing loads
// and stores over the data bus. Stalls earlier stages while a bus access is
// outstanding, aligns store data/strobe and extracts/extends load data.
// Ports:
//   clk, reset          clock; asynchronous active-high reset
//   dataE_*_i           execute result (held stable while stallM_o is high)
//   flushM_i            discard the instruction currently in MEM
//   dbus                data bus (master side)
//   stallM_o            hold EX and earlier stages
//   misalignM_o         one-cycle pulse: misaligned access dropped
//   dataM_*_o           registered result to writeback

module memory_stage #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            dataE_valid_i,
  input  logic [XLEN-1:0] dataE_pc_i,
  input  logic [31:0]     dataE_raw_instr_i,
  input  logic [4:0]      dataE_dst_i,
  input  logic [4:0]      dataE_ra1_i,
  input  logic [4:0]      dataE_ra2_i,
  input  logic            dataE_memread_i,
  input  logic            dataE_memwrite_i,
  input  logic [2:0]      dataE_msize_i,
  input  logic            dataE_zext_i,
  input  logic            dataE_regwrite_i,
  input  logic [XLEN-1:0] dataE_aluout_i,
  input  logic [XLEN-1:0] dataE_memwdata_i,
  input  logic            flushM_i,
  memory_stage_if.master  dbus,
  output logic            stallM_o,
  output logic            misalignM_o,
  output logic            dataM_valid_o,
  output logic [XLEN-1:0] dataM_pc_o,
  output logic [31:0]     dataM_raw_instr_o,
  output logic [4:0]      dataM_dst_o,
  output logic [4:0]      dataM_ra1_o,
  output logic [4:0]      dataM_ra2_o,
  output logic            dataM_memread_o,
  output logic            dataM_memwrite_o,
  output logic [2:0]      dataM_msize_o,
  output logic            dataM_zext_o,
  output logic            dataM_regwrite_o,
  output logic [XLEN-1:0] dataM_writedata_o
);

  typedef enum logic {IDLE, ACCESS} state_t;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [31:0]     raw_instr;
    logic [4:0]      dst;
    logic [4:0]      ra1;
    logic [4:0]      ra2;
    logic            memread;
    logic            memwrite;
    logic [2:0]      msize;
    logic            zext;
    logic            regwrite;
    logic [XLEN-1:0] writedata;
  } mem_rec_t;

  state_t          state_q, state_d;
  logic            req_valid_q, req_valid_d;
  logic [XLEN-1:0] req_addr_q, req_addr_d;
  logic [2:0]      req_size_q, req_size_d;
  logic [7:0]      req_strobe_q, req_strobe_d;
  logic [XLEN-1:0] req_data_q, req_data_d;
  logic            flushed_q, flushed_d;
  logic            misalign_q, misalign_d;
  mem_rec_t        dataM_q, dataM_d;

  logic            stall;
  logic            is_mem;
  logic            misaligned;
  logic [2:0]      off;
  logic [7:0]      byte_mask;
  logic [7:0]      store_strobe;
  logic [XLEN-1:0] store_data;
  logic [XLEN-1:0] load_raw;
  logic [XLEN-1:0] load_data;
  mem_rec_t        exec_rec;

  // The memory does not use a separate address phase here, so addr_ok has no effect.
  logic unused_addr_ok;
  assign unused_addr_ok = dbus.dresp_addr_ok;

  assign off    = dataE_aluout_i[2:0];
  assign is_mem = dataE_memread_i | dataE_memwrite_i;

  always_comb begin
    byte_mask  = 8'h01;
    misaligned = 1'b0;
    case (dataE_msize_i[1:0])
      2'd0:    begin byte_mask = 8'h01; misaligned = 1'b0;      end
      2'd1:    begin byte_mask = 8'h03; misaligned = off[0];    end
      2'd2:    begin byte_mask = 8'h0F; misaligned = |off[1:0]; end
      default: begin byte_mask = 8'hFF; misaligned = |off;      end
    endcase
  end

  assign store_strobe = byte_mask << off;
  assign store_data   = dataE_memwdata_i << {off, 3'b000};

  // Load extraction uses the latched request; only zext comes from the held dataE.
  assign load_raw = dbus.dresp_data >> {req_addr_q[2:0], 3'b000};

  always_comb begin
    load_data = load_raw;
    case (req_size_q[1:0])
      2'd0: load_data = dataE_zext_i ? {{(XLEN-8){1'b0}}, load_raw[7:0]}
                                     : {{(XLEN-8){load_raw[7]}}, load_raw[7:0]};
      2'd1: load_data = dataE_zext_i ? {{(XLEN-16){1'b0}}, load_raw[15:0]}
                                     : {{(XLEN-16){load_raw[15]}}, load_raw[15:0]};
      2'd2: load_data = dataE_zext_i ? {{(XLEN-32){1'b0}}, load_raw[31:0]}
                                     : {{(XLEN-32){load_raw[31]}}, load_raw[31:0]};
      default: load_data = load_raw;
    endcase
  end

  always_comb begin
    exec_rec           = '0;
    exec_rec.valid     = 1'b1;
    exec_rec.pc        = dataE_pc_i;
    exec_rec.raw_instr = dataE_raw_instr_i;
    exec_rec.dst       = dataE_dst_i;
    exec_rec.ra1       = dataE_ra1_i;
    exec_rec.ra2       = dataE_ra2_i;
    exec_rec.memread   = dataE_memread_i;
    exec_rec.memwrite  = dataE_memwrite_i;
    exec_rec.msize     = dataE_msize_i;
    exec_rec.zext      = dataE_zext_i;
    exec_rec.regwrite  = dataE_regwrite_i;
    exec_rec.writedata = dataE_aluout_i;
  end

  always_comb begin
    state_d      = state_q;
    req_valid_d  = req_valid_q;
    req_addr_d   = req_addr_q;
    req_size_d   = req_size_q;
    req_strobe_d = req_strobe_q;
    req_data_d   = req_data_q;
    flushed_d    = flushed_q;
    misalign_d   = 1'b0;
    stall        = 1'b0;
    dataM_d      = '0;  // bubble unless something is captured this edge
    case (state_q)
      IDLE: begin
        if (dataE_valid_i && !flushM_i) begin
          if (!is_mem) begin
            dataM_d = exec_rec;
          end else if (misaligned) begin
            dataM_d           = exec_rec;
            dataM_d.regwrite  = 1'b0;
            dataM_d.writedata = '0;
            misalign_d        = 1'b1;
          end else begin
            stall        = 1'b1;
            state_d      = ACCESS;
            req_valid_d  = 1'b1;
            req_addr_d   = dataE_aluout_i;
            req_size_d   = dataE_msize_i;
            req_strobe_d = dataE_memwrite_i ? store_strobe : 8'h00;
            req_data_d   = dataE_memwrite_i ? store_data : '0;
            flushed_d    = 1'b0;
          end
        end
      end
      ACCESS: begin
        // The transaction cannot be aborted: a flush only marks the result for dropping.
        stall = 1'b1;
        if (flushM_i) flushed_d = 1'b1;
        if (dbus.dresp_data_ok) begin
          state_d     = IDLE;
          req_valid_d = 1'b0;
          flushed_d   = 1'b0;
          if (!flushed_q && !flushM_i) begin
            dataM_d = exec_rec;
            if (dataE_memread_i) dataM_d.writedata = load_data;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      req_valid_q  <= 1'b0;
      req_addr_q   <= '0;
      req_size_q   <= '0;
      req_strobe_q <= '0;
      req_data_q   <= '0;
      flushed_q    <= 1'b0;
      misalign_q   <= 1'b0;
      dataM_q      <= '0;
    end else begin
      state_q      <= state_d;
      req_valid_q  <= req_valid_d;
      req_addr_q   <= req_addr_d;
      req_size_q   <= req_size_d;
      req_strobe_q <= req_strobe_d;
      req_data_q   <= req_data_d;
      flushed_q    <= flushed_d;
      misalign_q   <= misalign_d;
      dataM_q      <= dataM_d;
    end
  end

  assign dbus.dreq_valid  = req_valid_q;
  assign dbus.dreq_addr   = req_addr_q;
  assign dbus.dreq_size   = req_size_q;
  assign dbus.dreq_strobe = req_strobe_q;
  assign dbus.dreq_data   = req_data_q;

  assign stallM_o          = stall;
  assign misalignM_o       = misalign_q;
  assign dataM_valid_o     = dataM_q.valid;
  assign dataM_pc_o        = dataM_q.pc;
  assign dataM_raw_instr_o = dataM_q.raw_instr;
  assign dataM_dst_o       = dataM_q.dst;
  assign dataM_ra1_o       = dataM_q.ra1;
  assign dataM_ra2_o       = dataM_q.ra2;
  assign dataM_memread_o   = dataM_q.memread;
  assign dataM_memwrite_o  = dataM_q.memwrite;
  assign dataM_msize_o     = dataM_q.msize;
  assign dataM_zext_o      = dataM_q.zext;
  assign dataM_regwrite_o  = dataM_q.regwrite;
  assign dataM_writedata_o = dataM_q.writedata;

endmodule

// File: tb/tb_memory_stage.sv
// tb/tb_memory_stage.sv - randomized self-checking bench for memory_stage

module tb_memory_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        dataE_valid;
  logic [63:0] dataE_pc;
  logic [31:0] dataE_raw_instr;
  logic [4:0]  dataE_dst, dataE_ra1, dataE_ra2;
  logic        dataE_memread, dataE_memwrite;
  logic [2:0]  dataE_msize;
  logic        dataE_zext, dataE_regwrite;
  logic [63:0] dataE_aluout, dataE_memwdata;
  logic        flushM;
  logic        stallM, misalignM;
  logic        dataM_valid;
  logic [63:0] dataM_pc;
  logic [31:0] dataM_raw_instr;
  logic [4:0]  dataM_dst, dataM_ra1, dataM_ra2;
  logic        dataM_memread, dataM_memwrite;
  logic [2:0]  dataM_msize;
  logic        dataM_zext, dataM_regwrite;
  logic [63:0] dataM_writedata;

  memory_stage_if dbus();

  always #5 clk = ~clk;

  memory_stage #(.XLEN(64)) dut (
    .clk               (clk),
    .reset             (reset),
    .dataE_valid_i     (dataE_valid),
    .dataE_pc_i        (dataE_pc),
    .dataE_raw_instr_i (dataE_raw_instr),
    .dataE_dst_i       (dataE_dst),
    .dataE_ra1_i       (dataE_ra1),
    .dataE_ra2_i       (dataE_ra2),
    .dataE_memread_i   (dataE_memread),
    .dataE_memwrite_i  (dataE_memwrite),
    .dataE_msize_i     (dataE_msize),
    .dataE_zext_i      (dataE_zext),
    .dataE_regwrite_i  (dataE_regwrite),
    .dataE_aluout_i    (dataE_aluout),
    .dataE_memwdata_i  (dataE_memwdata),
    .flushM_i          (flushM),
    .dbus              (dbus),
    .stallM_o          (stallM),
    .misalignM_o       (misalignM),
    .dataM_valid_o     (dataM_valid),
    .dataM_pc_o        (dataM_pc),
    .dataM_raw_instr_o (dataM_raw_instr),
    .dataM_dst_o       (dataM_dst),
    .dataM_ra1_o       (dataM_ra1),
    .dataM_ra2_o       (dataM_ra2),
    .dataM_memread_o   (dataM_memread),
    .dataM_memwrite_o  (dataM_memwrite),
    .dataM_msize_o     (dataM_msize),
    .dataM_zext_o      (dataM_zext),
    .dataM_regwrite_o  (dataM_regwrite),
    .dataM_writedata_o (dataM_writedata)
  );

  typedef struct {
    logic        valid;
    logic [63:0] pc;
    logic [31:0] raw;
    logic [4:0]  dst, ra1, ra2;
    logic        memread, memwrite;
    logic [2:0]  msize;
    logic        zext, regwrite;
    logic [63:0] aluout, memwdata;
  } instr_t;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int nbytes(input logic [2:0] s);
    return 1 << int'(s[1:0]);
  endfunction

  function automatic int offset(input instr_t t);
    return int'(t.aluout[2:0]);
  endfunction

  function automatic bit is_misaligned(input instr_t t);
    return (offset(t) % nbytes(t.msize)) != 0;
  endfunction

  function automatic logic [7:0] model_strobe(input instr_t t);
    logic [15:0] m;
    m = ((16'd1 << nbytes(t.msize)) - 16'd1) << offset(t);
    return m[7:0];
  endfunction

  function automatic logic [63:0] model_wdata(input instr_t t);
    return t.memwdata << (8 * offset(t));
  endfunction

  function automatic logic [63:0] model_load(input instr_t t, input logic [63:0] rdata);
    logic [63:0] v, mask;
    int bits;
    v    = rdata >> (8 * offset(t));
    bits = 8 * nbytes(t.msize);
    if (bits == 64) return v;
    mask = (64'd1 << bits) - 64'd1;
    v    = v & mask;
    if (!t.zext && v[bits-1]) v = v | ~mask;
    return v;
  endfunction

  function automatic instr_t blank();
    instr_t t;
    t.valid = 1'b0; t.pc = '0; t.raw = '0; t.dst = '0; t.ra1 = '0; t.ra2 = '0;
    t.memread = 1'b0; t.memwrite = 1'b0; t.msize = '0; t.zext = 1'b0;
    t.regwrite = 1'b0; t.aluout = '0; t.memwdata = '0;
    return t;
  endfunction

  function automatic instr_t rand_instr();
    instr_t t;
    int kind;
    t          = blank();
    t.valid    = ($urandom_range(0, 9) != 0);
    t.pc       = {$urandom, $urandom};
    t.raw      = $urandom;
    t.dst      = 5'($urandom_range(0, 31));
    t.ra1      = 5'($urandom_range(0, 31));
    t.ra2      = 5'($urandom_range(0, 31));
    kind       = $urandom_range(0, 2);
    t.memread  = (kind == 1);
    t.memwrite = (kind == 2);
    t.msize    = 3'($urandom_range(0, 3));
    t.zext     = 1'($urandom_range(0, 1));
    t.regwrite = (kind != 2);
    t.aluout   = {$urandom, $urandom};
    if ($urandom_range(0, 3) != 0) t.aluout = t.aluout & ~(64'(nbytes(t.msize)) - 64'd1);
    t.memwdata = {$urandom, $urandom};
    return t;
  endfunction

  task automatic drive(input instr_t t, input logic flush);
    dataE_valid = t.valid;      dataE_pc = t.pc;             dataE_raw_instr = t.raw;
    dataE_dst = t.dst;          dataE_ra1 = t.ra1;           dataE_ra2 = t.ra2;
    dataE_memread = t.memread;  dataE_memwrite = t.memwrite; dataE_msize = t.msize;
    dataE_zext = t.zext;        dataE_regwrite = t.regwrite; dataE_aluout = t.aluout;
    dataE_memwdata = t.memwdata;
    flushM = flush;
  endtask

  // Called at a negedge; returns at the negedge after the capture edge, with dataM checked.
  task automatic run(input instr_t t, input bit flush_idle, input int delay,
                     input int flush_at, input logic [63:0] rdata, output int stall_cycles);
    bit mem, mis, access, dropped;
    mem     = t.valid && (t.memread || t.memwrite);
    mis     = mem && is_misaligned(t);
    access  = mem && !flush_idle && !mis;
    dropped = flush_idle || !t.valid;
    stall_cycles = 0;
    drive(t, flush_idle);
    dbus.dresp_data_ok = 1'b0;
    #1;
    check("stall_entry", stallM, access);
    if (stallM) stall_cycles++;
    if (access) begin
      for (int k = 1; k <= delay; k++) begin
        @(negedge clk);
        flushM = (k == flush_at);
        if (k == flush_at) dropped = 1'b1;
        dbus.dresp_addr_ok = 1'($urandom_range(0, 1));
        dbus.dresp_data_ok = (k == delay);
        dbus.dresp_data    = (k == delay) ? rdata : {$urandom, $urandom};
        #1;
        check("dreq_valid", dbus.dreq_valid, 1);
        check("dreq_addr", dbus.dreq_addr, t.aluout);
        check("dreq_size", dbus.dreq_size, t.msize);
        if (t.memwrite) begin
          check("dreq_strobe", dbus.dreq_strobe, model_strobe(t));
          check("dreq_data", dbus.dreq_data, model_wdata(t));
        end
        check("stall_access", stallM, 1);
        if (stallM) stall_cycles++;
        check("bubble_valid", dataM_valid, 0);
        check("misalign_idle", misalignM, 0);
      end
    end
    @(negedge clk);
    flushM = 1'b0;
    dbus.dresp_data_ok = 1'b0;
    check("dataM_valid", dataM_valid, !dropped);
    if (!dropped) begin
      check("dataM_pc", dataM_pc, t.pc);
      check("dataM_dst", dataM_dst, t.dst);
      if (mis) begin
        check("mis_regwrite", dataM_regwrite, 0);
        check("mis_writedata", dataM_writedata, 0);
      end else if (t.memread) begin
        check("load_writedata", dataM_writedata, model_load(t, rdata));
        check("load_regwrite", dataM_regwrite, t.regwrite);
      end else if (!t.memwrite) begin
        check("alu_writedata", dataM_writedata, t.aluout);
        check("alu_regwrite", dataM_regwrite, t.regwrite);
      end
    end
    check("misalignM", misalignM, mis && !flush_idle);
    check("dreq_idle", dbus.dreq_valid, 0);
  endtask

  initial begin
    instr_t t;
    int     sc;
    reset = 1'b1;
    drive(blank(), 1'b0);
    dbus.dresp_addr_ok = 1'b0;
    dbus.dresp_data_ok = 1'b0;
    dbus.dresp_data    = '0;
    @(negedge clk);
    @(negedge clk);
    check("rst_dataM_valid", dataM_valid, 0);
    check("rst_writedata", dataM_writedata, 0);
    check("rst_dreq_valid", dbus.dreq_valid, 0);
    check("rst_stall", stallM, 0);
    check("rst_misalign", misalignM, 0);
    reset = 1'b0;
    @(negedge clk);

    // ADD
    t = blank(); t.valid = 1'b1; t.regwrite = 1'b1; t.aluout = 64'h1234; t.dst = 5'd3;
    run(t, 1'b0, 1, 0, 64'h0, sc);
    check("add_stall_cycles", 64'(sc), 0);

    // LB, data_ok in the third access cycle
    t = blank(); t.valid = 1'b1; t.memread = 1'b1; t.regwrite = 1'b1; t.msize = 3'd0;
    t.aluout = 64'h1003;
    run(t, 1'b0, 3, 0, 64'h0000_0000_8000_0000, sc);
    check("lb_stall_cycles", 64'(sc), 4);
    check("lb_writedata", dataM_writedata, 64'hFFFF_FFFF_FFFF_FF80);

    // SH
    t = blank(); t.valid = 1'b1; t.memwrite = 1'b1; t.msize = 3'd1;
    t.aluout = 64'h1006; t.memwdata = 64'hABCD;
    run(t, 1'b0, 1, 0, 64'h0, sc);

    // LW misaligned
    t = blank(); t.valid = 1'b1; t.memread = 1'b1; t.regwrite = 1'b1; t.msize = 3'd2;
    t.aluout = 64'h1002;
    run(t, 1'b0, 1, 0, 64'h0, sc);

    // LD flushed in access cycle 1, data_ok in cycle 3
    t = blank(); t.valid = 1'b1; t.memread = 1'b1; t.regwrite = 1'b1; t.msize = 3'd3;
    t.aluout = 64'h2000;
    run(t, 1'b0, 3, 1, 64'h1122_3344_5566_7788, sc);
    check("ld_flush_stall_cycles", 64'(sc), 4);

    // Reset mid-access, then an ADD with latency 1
    t = blank(); t.valid = 1'b1; t.memread = 1'b1; t.msize = 3'd3; t.aluout = 64'h3000;
    drive(t, 1'b0);
    @(negedge clk);
    @(negedge clk);
    #1;
    check("pre_rst_dreq_valid", dbus.dreq_valid, 1);
    reset = 1'b1;
    #1;
    check("midrst_dreq_valid", dbus.dreq_valid, 0);
    check("midrst_dataM_valid", dataM_valid, 0);
    drive(blank(), 1'b0);
    @(negedge clk);
    reset = 1'b0;
    t = blank(); t.valid = 1'b1; t.regwrite = 1'b1; t.aluout = 64'h55AA; t.pc = 64'h80;
    run(t, 1'b0, 1, 0, 64'h0, sc);

    // Randomized traffic
    for (int i = 0; i < 150; i++) begin
      bit          fi;
      int          dly, fat;
      logic [63:0] rd;
      t   = rand_instr();
      fi  = ($urandom_range(0, 9) == 0);
      dly = $urandom_range(1, 4);
      fat = ($urandom_range(0, 5) == 0) ? $urandom_range(1, dly) : 0;
      rd  = {$urandom, $urandom};
      run(t, fi, dly, fat, rd, sc);
      if ($urandom_range(0, 3) == 0) begin
        drive(blank(), 1'b0);
        #1;
        check("idle_stall", stallM, 0);
        @(negedge clk);
        check("idle_dataM_valid", dataM_valid, 0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
